multiplier_arbiter: RTL
=======================

// Module: multiplier_arbiter
// PURPOSE
// - Shares one combinational array_multiplier instance between NumReq requesters.
// - Round-robin grant; one operand pair accepted per cycle; registered result tagged with requester id.
// - Sits between multiple producers and a single multiplier datapath, saving area versus one multiplier each.
// PARAMETERS
// - Width   4  operand width in bits; product is 2*Width bits
// - NumReq  3  number of requesters, >= 2; IdW = $clog2(NumReq)
// PORTS
// - clk_i        in   1             single clock, all state on rising edge
// - rst_i        in   1             synchronous, active-high reset
// - req_valid_i  in   NumReq        requester n has an operand pair pending
// - req_ready_o  out  NumReq        one-hot grant: pair of requester n accepted this cycle
// - req_a_i      in   NumReq*Width  multiplicand, requester n at bits [n*Width +: Width]
// - req_b_i      in   NumReq*Width  multiplier, same packing
// - rsp_valid_o  out  1             rsp_* holds a valid result
// - rsp_ready_i  in   1             consumer takes result when rsp_valid_o && rsp_ready_i
// - rsp_id_o     out  IdW           index of requester that produced the result
// - rsp_product_o out 2*Width       unsigned product a*b
// BEHAVIOUR
// - Reset (rst_i=1 at clk edge): rsp_valid_o=0, rsp_id_o=0, rsp_product_o=0, rr pointer=0.
//   req_ready_o is all zero while rst_i=1. Reset mid-transfer drops any held result.
// - Output register state: EMPTY (rsp_valid_o=0) or FULL (rsp_valid_o=1).
// - can_accept = !rsp_valid_o || rsp_ready_i; same-cycle drain+refill allowed (full throughput).
// - Grant: when can_accept, the first n with req_valid_i[n], searching ptr, ptr+1, ... wrapping
//   mod NumReq. req_ready_o[n]=1 for that n only. Grant is combinational from req_valid_i, ptr, rsp state.
// - On grant of n: next cycle rsp_valid_o=1, rsp_id_o=n, rsp_product_o=a_n*b_n (latency 1 cycle);
//   ptr <= (n+1) mod NumReq (wrap NumReq-1 -> 0).
// - No grant and rsp_ready_i && rsp_valid_o: FULL -> EMPTY. No grant, no drain: hold all outputs, ptr.
// - FULL && !rsp_ready_i: req_ready_o=0, rsp_* stable until accepted (no change while stalled).
// - Requester rules: once req_valid_i[n]=1, keep it and operands stable until req_ready_o[n]=1.
// - Arithmetic: unsigned; product fits 2*Width bits, never truncated (15*15=225 at Width=4).
// - Datapath: one array_multiplier #(.Width(Width)) fed by muxed operands of granted requester.
// - Fairness: a continuously valid requester waits at most NumReq-1 grants.
// TESTING
// - Reset then single req0 a=2,b=7, rsp_ready_i=1 -> next cycle rsp_valid_o=1, id=0, product=14.
// - All 3 valid every cycle, rsp_ready_i=1 -> grants 0,1,2,0,... one per cycle; back-to-back rsp_valid_o.
// - req1 a=13,b=6 with rsp_ready_i=0 -> product=78 id=1 held, req_ready_o=0 until rsp_ready_i=1.
// - ptr=2, only req0 and req2 valid -> req2 granted first, then req0 (wrap); ptr ends at 1.
// - Boundaries: a=15,b=15 -> 225; a=0,b=5 -> 0; a=11,b=1 -> 11 (Width=4).
// - rst_i asserted while FULL and stalled -> next cycle rsp_valid_o=0, ptr=0, no grant during reset.

Source files
------------

// File: rtl/multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : array_multiplier
// Purpose  : Unsigned combinational array multiplier. Each bit of the
//            multiplier gates a shifted copy of the multiplicand; the rows
//            are accumulated into a full 2*WIDTH-bit product.
// Ports    : i_a       in   WIDTH     multiplicand
//            i_b       in   WIDTH     multiplier
//            o_product out  2*WIDTH   unsigned product, never truncated
// Revision : 1.0  initial release
// ============================================================================
module array_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_product
);

    logic [2*WIDTH-1:0] w_pp  [WIDTH];
    logic [2*WIDTH-1:0] w_acc [WIDTH+1];

    assign w_acc[0] = '0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_row
        assign w_pp[i]    = i_b[i] ? ({{WIDTH{1'b0}}, i_a} << i) : '0;
        assign w_acc[i+1] = w_acc[i] + w_pp[i];
    end

    assign o_product = w_acc[WIDTH];

endmodule

// ============================================================================
// Module   : multiplier_arbiter
// Purpose  : Shares one array_multiplier between NUM_REQ requesters using a
//            round-robin grant. One operand pair is accepted per cycle and the
//            product is registered together with the id of its requester.
// Ports    : clk_i          in   1               clock, rising edge
//            rst_i          in   1               synchronous active-high reset
//            req_valid_i    in   NUM_REQ         requester n has a pair pending
//            req_ready_o    out  NUM_REQ         one-hot grant this cycle
//            req_a_i        in   NUM_REQ*WIDTH   multiplicands, n at [n*WIDTH +: WIDTH]
//            req_b_i        in   NUM_REQ*WIDTH   multipliers, same packing
//            rsp_valid_o    out  1               result register holds a result
//            rsp_ready_i    in   1               consumer takes the result
//            rsp_id_o       out  IDW             requester that produced the result
//            rsp_product_o  out  2*WIDTH         unsigned product
// Revision : 1.0  initial release
// ============================================================================
module multiplier_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 3,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IDW-1:0]           rsp_id_o,
    output logic [2*WIDTH-1:0]       rsp_product_o
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]         r_state_q,   w_state_d;
    logic [IDW-1:0]     r_ptr_q,     w_ptr_d;
    logic [IDW-1:0]     r_id_q,      w_id_d;
    logic [2*WIDTH-1:0] r_product_q, w_product_d;

    logic               w_can_accept;
    logic               w_gnt_found;
    logic [IDW-1:0]     w_gnt_id;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDW:0]       w_sum_idx;
    logic [IDW-1:0]     w_idx;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [2*WIDTH-1:0] w_product;

    // A full register may be drained and refilled in the same cycle.
    assign w_can_accept = (r_state_q == S_EMPTY) || rsp_ready_i;

    // Round-robin search starting at the pointer; the first valid requester
    // found wins. No grant is issued while reset is asserted.
    always_comb begin
        w_grant     = '0;
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_sum_idx   = '0;
        w_idx       = '0;
        if (w_can_accept && !rst_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_sum_idx = {1'b0, r_ptr_q} + (IDW+1)'(k);
                if (w_sum_idx >= (IDW+1)'(NUM_REQ)) begin
                    w_sum_idx = w_sum_idx - (IDW+1)'(NUM_REQ);
                end
                w_idx = w_sum_idx[IDW-1:0];
                if (!w_gnt_found && req_valid_i[w_idx]) begin
                    w_gnt_found = 1'b1;
                    w_gnt_id    = w_idx;
                end
            end
            if (w_gnt_found) begin
                w_grant[w_gnt_id] = 1'b1;
            end
        end
    end

    // Operand mux feeding the single shared multiplier.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int n = 0; n < NUM_REQ; n++) begin
            if (w_gnt_id == IDW'(n)) begin
                w_a = req_a_i[n*WIDTH +: WIDTH];
                w_b = req_b_i[n*WIDTH +: WIDTH];
            end
        end
    end

    array_multiplier #(
        .WIDTH (WIDTH)
    ) u_mult (
        .i_a       (w_a),
        .i_b       (w_b),
        .o_product (w_product)
    );

    always_comb begin
        w_state_d   = r_state_q;
        w_ptr_d     = r_ptr_q;
        w_id_d      = r_id_q;
        w_product_d = r_product_q;
        if (w_gnt_found) begin
            w_state_d   = S_FULL;
            w_id_d      = w_gnt_id;
            w_product_d = w_product;
            w_ptr_d     = (w_gnt_id == IDW'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;
        end else if ((r_state_q == S_FULL) && rsp_ready_i) begin
            w_state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q   <= S_EMPTY;
            r_ptr_q     <= '0;
            r_id_q      <= '0;
            r_product_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_ptr_q     <= w_ptr_d;
            r_id_q      <= w_id_d;
            r_product_q <= w_product_d;
        end
    end

    assign req_ready_o   = w_grant;
    assign rsp_valid_o   = (r_state_q == S_FULL);
    assign rsp_id_o      = r_id_q;
    assign rsp_product_o = r_product_q;

endmodule
`default_nettype wire
